// File: rtl/la_fifo_pkg.sv
// la_fifo_pkg: shared definitions for the logic-analyser FIFO controller.
//   state_t         - controller state encoding (also exported on the state port)
//   EMPTY_BYTE      - byte returned to the host when a read cannot be served
//   DEFAULT_DEPTH   - default FIFO capacity in bytes
//   DEFAULT_LEVEL_W - default occupancy counter width (2**W > DEPTH)
//   trig_match()    - masked trigger comparison
package la_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FLUSH   = 3'd1,
    ST_ARMED   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [7:0] EMPTY_BYTE      = 8'hEE;
  localparam int         DEFAULT_DEPTH   = 256;
  localparam int         DEFAULT_LEVEL_W = 9;

  // A bit only takes part in the comparison when its mask bit is 1.
  function automatic logic trig_match(input logic [7:0] sample,
                                      input logic [7:0] value,
                                      input logic [7:0] mask);
    return ((sample ^ value) & mask) == 8'h00;
  endfunction

endpackage

// File: rtl/capture_timebase.sv
// capture_timebase: sample-period generator for the capture engine.
//   clk, reset  - system clock, synchronous active-high reset
//   load        - restart the period (asserted on the trigger cycle)
//   divider     - sample period minus 1, in clocks
//   tick        - high for one cycle every divider+1 clocks after a load
module capture_timebase #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DIV_W-1:0] divider,
  output logic             tick
);

  logic [DIV_W-1:0] count;

  // Down-counter that reloads on trigger and on expiry, so ticks repeat every divider+1 clocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= divider;
    end else if (count == '0) begin
      count <= divider;
    end else begin
      count <= count - DIV_W'(1);
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/fifo_capture_ctrl.sv
// fifo_capture_ctrl: sequencer/arbiter for the byte FIFO behind the SPI port.
//   clk, reset                 - system clock, synchronous active-high reset
//   cfg_arm / cfg_abort        - start flush+arm / stop capture (pulses)
//   cfg_trig_value/_mask       - trigger pattern and care bits
//   cfg_divider / cfg_count    - sample period-1, samples to take (0 = until full)
//   sample_in                  - probe inputs
//   host_wr, host_wr_data      - host byte write
//   host_rd, host_rd_data/_valid - host read request and response
//   fifo_write/_data, fifo_read, fifo_read_data/_ready - FIFO port pair
//   state, level, full, empty, overflow - status
// The FIFO has no flags, so occupancy is tracked here: level moves on the
// same edge that launches the matching strobe.
module fifo_capture_ctrl
  import la_fifo_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LEVEL_W = DEFAULT_LEVEL_W,
  parameter int DIV_W   = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_arm,
  input  logic               cfg_abort,
  input  logic [7:0]         cfg_trig_value,
  input  logic [7:0]         cfg_trig_mask,
  input  logic [DIV_W-1:0]   cfg_divider,
  input  logic [CNT_W-1:0]   cfg_count,
  input  logic [7:0]         sample_in,
  input  logic               host_wr,
  input  logic [7:0]         host_wr_data,
  input  logic               host_rd,
  output logic [7:0]         host_rd_data,
  output logic               host_rd_valid,
  output logic               fifo_write,
  output logic [7:0]         fifo_write_data,
  output logic               fifo_read,
  input  logic [7:0]         fifo_read_data,
  input  logic               fifo_read_ready,
  output logic [2:0]         state,
  output logic [LEVEL_W-1:0] level,
  output logic               full,
  output logic               empty,
  output logic               overflow
);

  localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(DEPTH);

  state_t             cur_state;
  state_t             next_state;
  logic [7:0]         trig_value;
  logic [7:0]         trig_mask;
  logic [DIV_W-1:0]   divider;
  logic [CNT_W-1:0]   count_target;
  logic [CNT_W-1:0]   wr_count;
  logic [7:0]         sample_q;
  logic               rd_busy;
  logic               tick;
  logic               is_full;
  logic               is_empty;
  logic               rd_accept;
  logic               trig_hit;
  logic               cap_due;
  logic               tb_load;
  logic               arm_go;
  logic               wr_go;
  logic [7:0]         wr_byte;
  logic               rd_go;
  logic               host_rd_fifo;
  logic               host_rd_empty;
  logic               ovf_set;
  logic               cnt_inc;
  logic               last_sample;
  logic [LEVEL_W-1:0] level_next;

  assign is_full     = (level == FULL_LEVEL);
  assign is_empty    = (level == '0);
  // A request is only taken while no FIFO-backed read is still in flight.
  assign rd_accept   = host_rd && !rd_busy;
  assign trig_hit    = trig_match(sample_q, trig_value, trig_mask);
  assign last_sample = (count_target != '0) && ((wr_count + CNT_W'(1)) == count_target);
  assign state       = cur_state;

  capture_timebase #(.DIV_W(DIV_W)) u_timebase (
    .clk     (clk),
    .reset   (reset),
    .load    (tb_load),
    .divider (divider),
    .tick    (tick)
  );

  // Per-cycle decisions: next state, write-port owner, FIFO reads, host read routing.
  always_comb begin
    next_state    = cur_state;
    wr_go         = 1'b0;
    wr_byte       = 8'h00;
    rd_go         = 1'b0;
    host_rd_fifo  = 1'b0;
    host_rd_empty = 1'b0;
    ovf_set       = 1'b0;
    cnt_inc       = 1'b0;
    arm_go        = 1'b0;
    cap_due       = 1'b0;
    tb_load       = 1'b0;
    case (cur_state)
      ST_IDLE, ST_DONE: begin
        if (cfg_arm) begin
          arm_go     = 1'b1;
          next_state = ST_FLUSH;
        end else begin
          next_state = cur_state;
        end
        if (host_wr && is_full) begin
          ovf_set = 1'b1;
        end else if (host_wr) begin
          wr_go   = 1'b1;
          wr_byte = host_wr_data;
        end else begin
          wr_go = 1'b0;
        end
        if (rd_accept && !is_empty) begin
          rd_go        = 1'b1;
          host_rd_fifo = 1'b1;
        end else begin
          host_rd_empty = rd_accept;
        end
      end
      ST_FLUSH: begin
        host_rd_empty = rd_accept;
        if (!is_empty) begin
          rd_go      = 1'b1;
          // Leave on the cycle the last byte is drained.
          next_state = (level == LEVEL_W'(1)) ? ST_ARMED : ST_FLUSH;
        end else begin
          next_state = ST_ARMED;
        end
      end
      ST_ARMED: begin
        host_rd_empty = rd_accept;
        if (cfg_abort) begin
          next_state = ST_IDLE;
        end else if (trig_hit) begin
          cap_due = 1'b1;
          tb_load = 1'b1;
        end else begin
          next_state = ST_ARMED;
        end
      end
      ST_CAPTURE: begin
        host_rd_empty = rd_accept;
        if (cfg_abort) begin
          next_state = ST_DONE;
        end else begin
          cap_due = tick;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
    // The trigger sample and every later tick share one write path.
    if (cap_due && is_full) begin
      ovf_set    = 1'b1;
      next_state = ST_DONE;
    end else if (cap_due) begin
      wr_go      = 1'b1;
      wr_byte    = sample_q;
      cnt_inc    = 1'b1;
      next_state = last_sample ? ST_DONE : ST_CAPTURE;
    end else begin
      cnt_inc = 1'b0;
    end
  end

  // Occupancy follows the strobes being launched; write+read together cancel.
  always_comb begin
    if (wr_go && !rd_go) begin
      level_next = level + LEVEL_W'(1);
    end else if (rd_go && !wr_go) begin
      level_next = level - LEVEL_W'(1);
    end else begin
      level_next = level;
    end
  end

  // Controller state, strobes, status and host response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state       <= ST_IDLE;
      level           <= '0;
      full            <= 1'b0;
      empty           <= 1'b1;
      overflow        <= 1'b0;
      fifo_write      <= 1'b0;
      fifo_write_data <= 8'h00;
      fifo_read       <= 1'b0;
      host_rd_data    <= 8'h00;
      host_rd_valid   <= 1'b0;
      rd_busy         <= 1'b0;
      sample_q        <= 8'h00;
      trig_value      <= 8'h00;
      trig_mask       <= 8'h00;
      divider         <= '0;
      count_target    <= '0;
      wr_count        <= '0;
    end else begin
      cur_state       <= next_state;
      level           <= level_next;
      full            <= (level_next == FULL_LEVEL);
      empty           <= (level_next == '0);
      fifo_write      <= wr_go;
      fifo_write_data <= wr_byte;
      fifo_read       <= rd_go;
      sample_q        <= sample_in;
      overflow        <= arm_go ? 1'b0 : (overflow | ovf_set);
      if (arm_go) begin
        trig_value   <= cfg_trig_value;
        trig_mask    <= cfg_trig_mask;
        divider      <= cfg_divider;
        count_target <= cfg_count;
        wr_count     <= '0;
      end else if (cnt_inc) begin
        wr_count <= wr_count + CNT_W'(1);
      end else begin
        wr_count <= wr_count;
      end
      // Flush reads also return ready; only a pending host read is forwarded.
      if (rd_busy && fifo_read_ready) begin
        host_rd_valid <= 1'b1;
        host_rd_data  <= fifo_read_data;
        rd_busy       <= 1'b0;
      end else if (host_rd_empty) begin
        host_rd_valid <= 1'b1;
        host_rd_data  <= EMPTY_BYTE;
      end else if (host_rd_fifo) begin
        host_rd_valid <= 1'b0;
        rd_busy       <= 1'b1;
      end else begin
        host_rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_capture_ctrl.sv
// tb_fifo_capture_ctrl: directed bench for fifo_capture_ctrl with a byte FIFO model.
module tb_fifo_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_arm = 1'b0;
  logic        cfg_abort = 1'b0;
  logic [7:0]  cfg_trig_value = 8'h00;
  logic [7:0]  cfg_trig_mask = 8'h00;
  logic [15:0] cfg_divider = 16'd0;
  logic [15:0] cfg_count = 16'd0;
  logic [7:0]  sample_in = 8'h00;
  logic        host_wr = 1'b0;
  logic [7:0]  host_wr_data = 8'h00;
  logic        host_rd = 1'b0;
  logic [7:0]  host_rd_data;
  logic        host_rd_valid;
  logic        fifo_write;
  logic [7:0]  fifo_write_data;
  logic        fifo_read;
  logic [7:0]  fifo_read_data;
  logic        fifo_read_ready;
  logic [2:0]  state;
  logic [8:0]  level;
  logic        full;
  logic        empty;
  logic        overflow;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] mem [0:255];
  logic [7:0] wptr;
  logic [7:0] rptr;

  always #5 clk = ~clk;

  fifo_capture_ctrl dut (
    .clk(clk), .reset(reset), .cfg_arm(cfg_arm), .cfg_abort(cfg_abort),
    .cfg_trig_value(cfg_trig_value), .cfg_trig_mask(cfg_trig_mask),
    .cfg_divider(cfg_divider), .cfg_count(cfg_count), .sample_in(sample_in),
    .host_wr(host_wr), .host_wr_data(host_wr_data), .host_rd(host_rd),
    .host_rd_data(host_rd_data), .host_rd_valid(host_rd_valid),
    .fifo_write(fifo_write), .fifo_write_data(fifo_write_data),
    .fifo_read(fifo_read), .fifo_read_data(fifo_read_data),
    .fifo_read_ready(fifo_read_ready), .state(state), .level(level),
    .full(full), .empty(empty), .overflow(overflow)
  );

  // Byte FIFO model: read data and ready appear the cycle after fifo_read.
  always @(posedge clk) begin
    if (reset) begin
      wptr <= 8'd0;
      rptr <= 8'd0;
      fifo_read_ready <= 1'b0;
      fifo_read_data <= 8'h00;
    end else begin
      if (fifo_write) begin
        mem[wptr] <= fifo_write_data;
        wptr <= wptr + 8'd1;
      end
      if (fifo_read) begin
        fifo_read_data <= mem[rptr];
        fifo_read_ready <= 1'b1;
        rptr <= rptr + 8'd1;
      end else begin
        fifo_read_ready <= 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rd_valid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (host_rd_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_checks++; if (level !== 9'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
    n_checks++; if ({empty, full, overflow} !== 3'b100) begin n_fail++; $display("FAIL reset_flags: got %b expected 100", {empty, full, overflow}); end
    n_checks++; if ({fifo_write, fifo_read, host_rd_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes: got %b expected 000", {fifo_write, fifo_read, host_rd_valid}); end
    n_checks++; if (host_rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 00", host_rd_data); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_host_rw();
    bit got;
    logic [7:0] exp_data [0:1];
    exp_data[0] = 8'h11;
    exp_data[1] = 8'h22;
    for (int i = 0; i < 2; i++) begin
      host_wr = 1'b1; host_wr_data = exp_data[i];
      step();
      host_wr = 1'b0;
      n_checks++; if ({fifo_write, fifo_write_data} !== {1'b1, exp_data[i]}) begin n_fail++; $display("FAIL host_wr_strobe%0d: got %b/%h expected 1/%h", i, fifo_write, fifo_write_data, exp_data[i]); end
      n_checks++; if (level !== 9'(i + 1)) begin n_fail++; $display("FAIL host_wr_level%0d: got %0d expected %0d", i, level, i + 1); end
    end
    step();
    for (int i = 0; i < 2; i++) begin
      host_rd = 1'b1;
      step();
      host_rd = 1'b0;
      n_checks++; if (fifo_read !== 1'b1) begin n_fail++; $display("FAIL host_rd_strobe%0d: got %b expected 1", i, fifo_read); end
      n_checks++; if (level !== 9'(1 - i)) begin n_fail++; $display("FAIL host_rd_level%0d: got %0d expected %0d", i, level, 1 - i); end
      wait_rd_valid(got);
      n_checks++; if (got !== 1'b1 || host_rd_data !== exp_data[i]) begin n_fail++; $display("FAIL host_rd_data%0d: got valid=%b data=%h expected valid=1 data=%h", i, got, host_rd_data, exp_data[i]); end
    end
    host_rd = 1'b1;
    step();
    host_rd = 1'b0;
    n_checks++; if ({host_rd_valid, host_rd_data} !== 9'h1EE) begin n_fail++; $display("FAIL host_rd_empty: got %b/%h expected 1/ee", host_rd_valid, host_rd_data); end
    n_checks++; if (fifo_read !== 1'b0) begin n_fail++; $display("FAIL host_rd_empty_noread: got %b expected 0", fifo_read); end
    n_checks++; if ({empty, level} !== {1'b1, 9'd0}) begin n_fail++; $display("FAIL host_rd_empty_level: got empty=%b level=%0d expected 1/0", empty, level); end
  endtask

  task automatic test_flush();
    int n = 0;
    int iters = 0;
    for (int i = 0; i < 5; i++) begin
      host_wr = 1'b1; host_wr_data = 8'h30 + 8'(i);
      step();
    end
    host_wr = 1'b0;
    step();
    n_checks++; if (level !== 9'd5) begin n_fail++; $display("FAIL flush_prefill: got %0d expected 5", level); end
    cfg_trig_value = 8'hA5; cfg_trig_mask = 8'hF0; cfg_divider = 16'd2; cfg_count = 16'd4;
    sample_in = 8'h00;
    cfg_arm = 1'b1;
    step();
    cfg_arm = 1'b0;
    n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL flush_enter: got %0d expected 1", state); end
    while (state === 3'd1 && iters < 20) begin
      step();
      iters++;
      if (fifo_read === 1'b1) n++;
    end
    n_checks++; if (n !== 5 || iters !== 5) begin n_fail++; $display("FAIL flush_reads: got %0d reads in %0d cycles expected 5 in 5", n, iters); end
    n_checks++; if ({state, level} !== {3'd2, 9'd0}) begin n_fail++; $display("FAIL flush_armed: got state=%0d level=%0d expected 2/0", state, level); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL flush_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_trigger();
    int n = 0;
    int t [0:7];
    logic [7:0] d [0:7];
    logic [7:0] exp_d;
    step();
    step();
    n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL trig_no_early: got %0d expected 2", state); end
    sample_in = 8'hA3;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (fifo_write === 1'b1 && n < 8) begin
        t[n] = k;
        d[n] = fifo_write_data;
        n++;
        sample_in = 8'h3C;
      end
    end
    n_checks++; if (n !== 4) begin n_fail++; $display("FAIL trig_write_count: got %0d expected 4", n); end
    for (int i = 0; i < 4 && i < n; i++) begin
      exp_d = (i == 0) ? 8'hA3 : 8'h3C;
      n_checks++; if (t[i] !== 2 + 3 * i || d[i] !== exp_d) begin n_fail++; $display("FAIL trig_write%0d: got cycle %0d data %h expected cycle %0d data %h", i, t[i], d[i], 2 + 3 * i, exp_d); end
    end
    n_checks++; if ({state, level} !== {3'd4, 9'd4}) begin n_fail++; $display("FAIL trig_done: got state=%0d level=%0d expected 4/4", state, level); end
  endtask

  task automatic test_overflow();
    int n = 0;
    int iters = 0;
    int extra = 0;
    cfg_trig_value = 8'h00; cfg_trig_mask = 8'h00; cfg_divider = 16'd0; cfg_count = 16'd0;
    cfg_arm = 1'b1;
    step();
    cfg_arm = 1'b0;
    while (state !== 3'd4 && iters < 600) begin
      step();
      iters++;
      if (fifo_write === 1'b1) n++;
    end
    n_checks++; if (n !== 256) begin n_fail++; $display("FAIL ovf_writes: got %0d expected 256", n); end
    n_checks++; if ({state, overflow, full} !== {3'd4, 1'b1, 1'b1}) begin n_fail++; $display("FAIL ovf_flags: got state=%0d ovf=%b full=%b expected 4/1/1", state, overflow, full); end
    n_checks++; if (level !== 9'd256) begin n_fail++; $display("FAIL ovf_level: got %0d expected 256", level); end
    for (int i = 0; i < 3; i++) begin
      step();
      if (fifo_write === 1'b1) extra++;
    end
    host_wr = 1'b1; host_wr_data = 8'h99;
    step();
    host_wr = 1'b0;
    if (fifo_write === 1'b1) extra++;
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL ovf_extra_writes: got %0d expected 0", extra); end
    n_checks++; if (level !== 9'd256) begin n_fail++; $display("FAIL ovf_host_drop: got %0d expected 256", level); end
  endtask

  task automatic test_rearm_clears();
    int n = 0;
    int iters = 0;
    cfg_trig_value = 8'h00; cfg_trig_mask = 8'hFF;
    sample_in = 8'h5A;
    cfg_arm = 1'b1;
    step();
    cfg_arm = 1'b0;
    n_checks++; if ({state, overflow} !== {3'd1, 1'b0}) begin n_fail++; $display("FAIL rearm_clear: got state=%0d ovf=%b expected 1/0", state, overflow); end
    while (state === 3'd1 && iters < 600) begin
      step();
      iters++;
      if (fifo_read === 1'b1) n++;
    end
    n_checks++; if (n !== 256) begin n_fail++; $display("FAIL rearm_reads: got %0d expected 256", n); end
    n_checks++; if ({state, level, empty} !== {3'd2, 9'd0, 1'b1}) begin n_fail++; $display("FAIL rearm_armed: got state=%0d level=%0d empty=%b expected 2/0/1", state, level, empty); end
  endtask

  task automatic test_abort();
    int n = 0;
    int iters = 0;
    int extra = 0;
    cfg_abort = 1'b1;
    step();
    cfg_abort = 1'b0;
    n_checks++; if ({state, level} !== {3'd0, 9'd0}) begin n_fail++; $display("FAIL abort_armed: got state=%0d level=%0d expected 0/0", state, level); end
    cfg_trig_mask = 8'h00; cfg_divider = 16'd3; cfg_count = 16'd0;
    cfg_arm = 1'b1;
    step();
    cfg_arm = 1'b0;
    while (n < 2 && iters < 40) begin
      step();
      iters++;
      if (fifo_write === 1'b1) n++;
    end
    n_checks++; if (n !== 2) begin n_fail++; $display("FAIL abort_prewrites: got %0d expected 2", n); end
    host_wr = 1'b1; host_wr_data = 8'h77;
    step();
    host_wr = 1'b0;
    n_checks++; if ({fifo_write, level} !== {1'b0, 9'd2}) begin n_fail++; $display("FAIL capture_host_wr: got wr=%b level=%0d expected 0/2", fifo_write, level); end
    host_rd = 1'b1;
    step();
    host_rd = 1'b0;
    n_checks++; if ({host_rd_valid, host_rd_data, fifo_read} !== {1'b1, 8'hEE, 1'b0}) begin n_fail++; $display("FAIL capture_host_rd: got valid=%b data=%h rd=%b expected 1/ee/0", host_rd_valid, host_rd_data, fifo_read); end
    n_checks++; if (state !== 3'd3) begin n_fail++; $display("FAIL capture_state: got %0d expected 3", state); end
    cfg_abort = 1'b1;
    step();
    cfg_abort = 1'b0;
    n_checks++; if ({state, level} !== {3'd4, 9'd2}) begin n_fail++; $display("FAIL abort_capture: got state=%0d level=%0d expected 4/2", state, level); end
    for (int i = 0; i < 6; i++) begin
      step();
      if (fifo_write === 1'b1) extra++;
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL abort_no_writes: got %0d expected 0", extra); end
  endtask

  task automatic test_reset_mid();
    int iters = 0;
    cfg_trig_mask = 8'h00; cfg_divider = 16'd1; cfg_count = 16'd0;
    cfg_arm = 1'b1;
    step();
    cfg_arm = 1'b0;
    while (state !== 3'd3 && iters < 20) begin
      step();
      iters++;
    end
    step();
    step();
    n_checks++; if (state !== 3'd3) begin n_fail++; $display("FAIL mid_capture_reached: got %0d expected 3", state); end
    reset = 1'b1;
    step();
    n_checks++; if ({state, level} !== {3'd0, 9'd0}) begin n_fail++; $display("FAIL mid_reset_state: got state=%0d level=%0d expected 0/0", state, level); end
    n_checks++; if ({fifo_write, fifo_read, host_rd_valid, overflow, empty} !== 5'b00001) begin n_fail++; $display("FAIL mid_reset_strobes: got %b expected 00001", {fifo_write, fifo_read, host_rd_valid, overflow, empty}); end
    reset = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_host_rw();
    test_flush();
    test_trigger();
    test_overflow();
    test_rearm_clears();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
